// File: rtl/clock_display_scan.sv
// Scans six BCD time digits onto an 8-position common-anode 7-segment display
// laid out HH-MM-SS. The time is snapshotted once per frame, and one field can blink.
module clock_display_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clkinput,
  input  logic       reset,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] hour_tens,
  input  logic [1:0] blink_sel,
  output logic [7:0] seg_out,
  output logic [7:0] an_out
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] FLD_NONE = 2'b00;
  localparam logic [1:0] FLD_SEC  = 2'b01;
  localparam logic [1:0] FLD_MIN  = 2'b10;
  localparam logic [1:0] FLD_HOUR = 2'b11;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic          blink_phase_q, blink_phase_d;
  logic          scan_tick, blink_tick, snap_en;

  logic [3:0] snap_sec_ones_q, snap_sec_tens_q;
  logic [3:0] snap_min_ones_q, snap_min_tens_q;
  logic [3:0] snap_hour_ones_q, snap_hour_tens_q;

  logic [3:0] pos_nib;
  logic [1:0] pos_field;
  logic       pos_sep;
  logic       pos_blank;
  logic [7:0] seg_d, an_d;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'h86;  // non-BCD nibble shows 'E'
    endcase
    return s;
  endfunction

  always_comb begin
    scan_tick     = (scan_cnt_q == SW'(SCAN_DIV - 1));
    blink_tick    = (blink_cnt_q == BW'(BLINK_DIV - 1));
    snap_en       = scan_tick && (digit_idx_q == 3'd7);
    scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + SW'(1);
    blink_cnt_d   = blink_tick ? '0 : blink_cnt_q + BW'(1);
    digit_idx_d   = scan_tick ? digit_idx_q + 3'd1 : digit_idx_q;
    blink_phase_d = blink_tick ? ~blink_phase_q : blink_phase_q;
  end

  always_comb begin
    pos_nib   = 4'd0;
    pos_field = FLD_NONE;
    pos_sep   = 1'b0;
    case (digit_idx_q)
      3'd0: begin pos_nib = snap_sec_ones_q;  pos_field = FLD_SEC;  end
      3'd1: begin pos_nib = snap_sec_tens_q;  pos_field = FLD_SEC;  end
      3'd3: begin pos_nib = snap_min_ones_q;  pos_field = FLD_MIN;  end
      3'd4: begin pos_nib = snap_min_tens_q;  pos_field = FLD_MIN;  end
      3'd6: begin pos_nib = snap_hour_ones_q; pos_field = FLD_HOUR; end
      3'd7: begin pos_nib = snap_hour_tens_q; pos_field = FLD_HOUR; end
      default: pos_sep = 1'b1;
    endcase
    pos_blank = blink_phase_q && (blink_sel != FLD_NONE) && (pos_field == blink_sel);
    if (pos_sep)        seg_d = SEG_DASH;
    else if (pos_blank) seg_d = SEG_BLANK;
    else                seg_d = seg7(pos_nib);
    an_d = ~(8'b1 << digit_idx_q);
  end

  always_ff @(posedge clkinput) begin
    if (!reset) begin
      scan_cnt_q       <= '0;
      blink_cnt_q      <= '0;
      digit_idx_q      <= 3'd0;
      blink_phase_q    <= 1'b0;
      snap_sec_ones_q  <= 4'd0;
      snap_sec_tens_q  <= 4'd0;
      snap_min_ones_q  <= 4'd0;
      snap_min_tens_q  <= 4'd0;
      snap_hour_ones_q <= 4'd0;
      snap_hour_tens_q <= 4'd0;
      seg_out          <= SEG_BLANK;
      an_out           <= 8'hFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_phase_q <= blink_phase_d;
      // Capture all six digits together on the 7->0 wrap so a frame never mixes two times.
      if (snap_en) begin
        snap_sec_ones_q  <= sec_ones;
        snap_sec_tens_q  <= sec_tens;
        snap_min_ones_q  <= min_ones;
        snap_min_tens_q  <= min_tens;
        snap_hour_ones_q <= hour_ones;
        snap_hour_tens_q <= hour_tens;
      end
      seg_out <= seg_d;
      an_out  <= an_d;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, BLINK_DIV=64.
// Inputs are driven and outputs sampled on the falling edge; e counts rising edges since reset release.
module tb_clock_display_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] so, st, mo, mt, ho, ht;
  logic [1:0] bsel;
  logic [7:0] seg, an;

  int checks = 0;
  int errors = 0;
  int e = 0;

  clock_display_scan #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
    .clkinput (clk),
    .reset    (rst_n),
    .sec_ones (so),
    .sec_tens (st),
    .min_ones (mo),
    .min_tens (mt),
    .hour_ones(ho),
    .hour_tens(ht),
    .blink_sel(bsel),
    .seg_out  (seg),
    .an_out   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at e=%0d: got %h expected %h", tag, e, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic goto(input int target);
    while (e < target) step(1);
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, f, g);
    ht = a; ho = b; mt = c; mo = d; st = f; so = g;
  endtask

  // Each window holds a position for 4 edges; e = 33+4p+1 lands mid-window in frame 2.
  logic [7:0] exp_1234 [8] = '{8'h82, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
  logic [7:0] exp_blnk [8] = '{8'h82, 8'h92, 8'hBF, 8'hFF, 8'hFF, 8'hBF, 8'hA4, 8'hF9};

  initial begin
    rst_n = 1'b0;
    bsel  = 2'b00;
    set_time(0, 0, 0, 0, 0, 0);

    // Reset and release
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    rst_n = 1'b1;
    e = 0;
    step(1);
    chk("rel_an", an, 8'hFE);
    chk("rel_seg", seg, 8'hC0);
    goto(4);
    chk("an_e4", an, 8'hFE);
    goto(5);
    chk("an_e5", an, 8'hFD);
    goto(28);
    chk("an_e28", an, 8'hBF);
    goto(29);
    chk("an_e29", an, 8'h7F);
    chk("seg_e29", seg, 8'hC0);

    // 12:34:56 captured at the wrap on edge 32, shown in frame 2
    set_time(1, 2, 3, 4, 5, 6);
    goto(31);
    chk("preframe_seg", seg, 8'hC0);
    for (int p = 0; p < 8; p++) begin
      goto(34 + 4 * p);
      chk("f2_an", an, ~(32'h1 << p) & 32'hFF);
      chk("f2_seg", seg, exp_1234[p]);
      if (p == 3) set_time(2, 3, 5, 9, 4, 8);  // mid-frame change must not show until frame 3
    end

    // Frame 3 (edges 65..96) shows 23:59:48; blink phase is 1 but nothing selected yet
    goto(66);
    chk("f3_p0", seg, 8'h80);
    set_time(1, 2, 3, 4, 5, 6);
    goto(70); chk("f3_p1", seg, 8'h99);
    goto(78); chk("f3_p3", seg, 8'h90);
    goto(82); chk("f3_p4", seg, 8'h92);
    goto(84);
    bsel = 2'b10;
    goto(86); chk("f3_p5", seg, 8'hBF);
    goto(90); chk("f3_p6", seg, 8'hB0);
    goto(94); chk("f3_p7", seg, 8'hA4);

    // Frame 4 (phase 1): minutes blank
    for (int p = 0; p < 8; p++) begin
      goto(98 + 4 * p);
      chk("blink_on", seg, exp_blnk[p]);
    end
    // Frame 5 (phase 0): minutes visible
    goto(142); chk("blink_off_p3", seg, 8'h99);
    goto(146); chk("blink_off_p4", seg, 8'hB0);
    so = 4'hC;

    // Frame 6: invalid BCD shows E
    goto(162); chk("bad_bcd", seg, 8'h86);
    goto(166); chk("bad_bcd_p1", seg, 8'h92);

    // Mid-frame reset with digit_idx=5 and blink phase 1
    goto(214);
    chk("pre_rst_an", an, 8'hDF);
    chk("pre_rst_seg", seg, 8'hBF);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_an", an, 8'hFF);
    chk("mid_rst_seg", seg, 8'hFF);
    rst_n = 1'b1;
    e = 0;
    step(1);
    chk("rst2_an", an, 8'hFE);
    chk("rst2_seg", seg, 8'hC0);
    goto(14); chk("rst2_p3", seg, 8'hC0);
    goto(18); chk("rst2_p4", seg, 8'hC0);
    goto(34); chk("rst2_f2_p0", seg, 8'h86);
    goto(46); chk("rst2_f2_p3", seg, 8'h99);
    goto(50); chk("rst2_f2_p4", seg, 8'hB0);

    // No selection: nothing blanks across several blink phases
    bsel = 2'b00;
    for (int i = 0; i < 300; i++) begin
      step(1);
      chk("noblank", {31'd0, seg == 8'hFF}, 32'd0);
      chk("an_onehot", $countones(~an), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream stage of the digital clock core: consumes the six BCD digits (seconds, minutes, hours; ones and tens each) and drives an 8-digit multiplexed common-anode 7-segment display.
- Layout is HH-MM-SS, with '-' on the two separator digits.
- Takes a frame-consistent snapshot of the time once per scan frame.
- Supports blinking one selected field, for time-setting feedback.

Parameters:
SCAN_DIV, 100000, clkinput cycles per digit slot (1 kHz digit rate at 100 MHz); legal values are 2 or more
BLINK_DIV, 25000000, clkinput cycles per blink half-period (2 Hz toggle at 100 MHz); legal values are 2 or more

Ports:
clkinput  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
sec_ones  in  4  BCD seconds ones digit
sec_tens  in  4  BCD seconds tens digit
min_ones  in  4  BCD minutes ones digit
min_tens  in  4  BCD minutes tens digit
hour_ones  in  4  BCD hours ones digit
hour_tens  in  4  BCD hours tens digit
blink_sel  in  2  00 none, 01 seconds, 10 minutes, 11 hours
seg_out  out  8  active-low segments; [0]=a … [6]=g, [7]=dp
an_out  out  8  active-low digit enables; bit i selects position i

Behaviour:
- Reset (reset==0 at an edge):
  - scan_cnt=0, blink_cnt=0, digit_idx=0, blink_phase=0.
  - All six snapshot registers=0.
  - an_out=8'hFF, seg_out=8'hFF (display dark).
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - scan_tick is asserted when scan_cnt==SCAN_DIV-1.
  - On scan_tick, digit_idx advances: 0→1→…→7→0.
- Snapshot:
  - On a scan_tick where digit_idx==7 (wrap to 0), all six inputs are captured together.
  - Inputs never feed the display directly, so a frame never mixes two time values.
  - The first frame after reset shows 00-00-00.
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV-1.
  - blink_phase toggles when blink_cnt==BLINK_DIV-1.
  - The blink counter runs independently of the scan counter.
- Position map (digit_idx):
  - 0 sec_ones, 1 sec_tens, 2 '-'.
  - 3 min_ones, 4 min_tens, 5 '-'.
  - 6 hour_ones, 7 hour_tens.
- Segment encoding (active-low):
  - Digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - '-'=BF, blank=FF.
  - Any snapshot nibble 10..15 shows 'E'=86.
  - dp is always off (bit7=1).
- Blanking:
  - Applies when blink_phase==1 and the current position belongs to the field selected by blink_sel.
  - A blanked position outputs seg_out=FF.
  - Separators are never blanked.
  - blink_sel is sampled combinationally into the output register, so a change takes effect on the next edge.
- Output register and latency:
  - an_out and seg_out are registered.
  - Each clock after reset: an_out <= ~(8'b1<<digit_idx), and seg_out <= encode(current position).
  - Outputs therefore lag digit_idx by exactly 1 cycle.
  - an_out always has exactly one bit low, except under reset.
- Reset mid-operation: takes effect at the next edge regardless of counter state. There is no partial-frame carryover.
- Simultaneous events: scan_tick and blink toggle in the same cycle are independent. A snapshot and a blink toggle in the same cycle both apply.

Test Plan:
1. Reset release, using SCAN_DIV=4, BLINK_DIV=64:
   - Hold reset=0 for 3 cycles: an_out=FF, seg_out=FF.
   - First edge with reset=1: an_out=FE, seg_out=C0.
   - an_out steps FE→FD→FB→… every 4 cycles and reaches 7F after 28 cycles.
2. Snapshot consistency:
   - Drive 12:34:56 and let one full frame complete.
   - Next frame shows seg per position: 0:82, 1:92, 2:BF, 3:99, 4:B0, 5:BF, 6:A4, 7:F9.
   - Change the inputs mid-frame: the displayed values change only after the next 7→0 wrap.
3. Blink:
   - blink_sel=10 with time 12:34:56: positions 3 and 4 show FF while blink_phase=1 (64-cycle windows) and 99/B0 otherwise.
   - Other positions are unaffected.
4. Invalid BCD: sec_ones=4'hC → position 0 shows 86.
5. Reset mid-frame:
   - Assert reset=0 for 1 cycle while digit_idx=5 and blink_phase=1.
   - Outputs go FF/FF, then restart at an_out=FE.
   - The display shows zeros until the first wrap; no blanking for 64 cycles.
6. blink_sel=00 over 300 cycles: no position ever shows FF after reset.
